// File: rtl/trng.sv
// True random number generator: a jittery oscillator is synchronised, sampled and
// XOR-folded 2^DEC_LEN samples per bit, and eight bits are packed into each output byte.
module trng #(
    parameter int unsigned DEC_LEN = 12
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clk2,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] out,
    output logic       rdy
);

    localparam logic [DEC_LEN-1:0] CNT_MAX = '1;

    logic               sync1_q;
    logic               sync2_q;
    logic               parity_q,  parity_d;
    logic [DEC_LEN-1:0] cnt_q,     cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         acc_q,     acc_d;
    logic [7:0]         out_q,     out_d;
    logic               rdy_q,     rdy_d;

    logic s;
    logic b;

    assign s   = sync2_q;
    assign b   = parity_q ^ s;
    assign out = out_q;
    assign rdy = rdy_q;

    // clk2 is only ever sampled as data; the synchroniser runs whether or not en is set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= clk2;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        parity_d  = parity_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        acc_d     = acc_q;
        out_d     = out_q;
        rdy_d     = rdy_q;

        // clr outranks a byte completing on the same edge, so that byte is dropped.
        if (clr) begin
            parity_d  = 1'b0;
            cnt_d     = '0;
            bit_cnt_d = 3'd0;
            rdy_d     = 1'b0;
        end else if (!en) begin
            parity_d  = 1'b0;
            cnt_d     = '0;
            bit_cnt_d = 3'd0;
        end else if (cnt_q == CNT_MAX) begin
            parity_d  = 1'b0;
            cnt_d     = '0;
            acc_d     = {acc_q[6:0], b};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                out_d = {acc_q[6:0], b};
                rdy_d = 1'b1;
            end
        end else begin
            parity_d = parity_q ^ s;
            cnt_d    = cnt_q + DEC_LEN'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            parity_q  <= 1'b0;
            cnt_q     <= '0;
            bit_cnt_q <= 3'd0;
            acc_q     <= 8'h00;
            out_q     <= 8'h00;
            rdy_q     <= 1'b0;
        end else begin
            parity_q  <= parity_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            rdy_q     <= rdy_d;
        end
    end

endmodule

// File: tb/tb_trng.sv
// Directed bench for trng with DEC_LEN=3 (8 samples per bit, 64 enabled cycles per byte).
// clk2 is driven from a phase counter so that enabled cycle i samples pattern value i.
module tb_trng;

    logic       clk;
    logic       resetn;
    logic       clk2;
    logic       en;
    logic       clr;
    logic [7:0] out;
    logic       rdy;

    int total;
    int bad;

    // Stimulus pattern selection: 0 const 0, 1 const 1, 2 period-8 single pulse,
    // 3 coded bytes b1 then b2, 4 coded byte b1 then const 1.
    int         kind;
    logic [7:0] b1;
    logic [7:0] b2;
    int         phase;

    typedef struct {
        int         kind;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] exp1;
        logic [7:0] exp2;
    } vec_t;

    vec_t vecs [6];

    trng #(.DEC_LEN(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .clk2   (clk2),
        .en     (en),
        .clr    (clr),
        .out    (out),
        .rdy    (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Window j covers phases 8j+1..8j+8; a coded 1 sits mid-window so the parity of
    // window j equals the byte bit that lands at out[7-j].
    function automatic logic pat(int p);
        int j;
        logic v;
        v = 1'b0;
        j = (p - 1) / 8;
        case (kind)
            0: v = 1'b0;
            1: v = 1'b1;
            2: v = (p % 8 == 0);
            3: if (p >= 1 && p <= 128 && ((p - 1) % 8) == 3)
                   v = (j < 8) ? b1[7 - j] : b2[15 - j];
            4: if (p > 64)
                   v = 1'b1;
               else if (p >= 1 && ((p - 1) % 8) == 3)
                   v = b1[7 - j];
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        phase++;
        clk2 = pat(phase);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Reset is asserted between edges so out/rdy must clear without a clock edge.
    task automatic do_reset(input string tag);
        resetn = 1'b0;
        en     = 1'b0;
        clr    = 1'b0;
        #2;
        check({tag, "_out"}, out, 8'h00);
        check({tag, "_rdy"}, {7'd0, rdy}, 8'h00);
        step();
        step();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        phase  = 0;
        clk2   = pat(0);
    endtask

    // Pre-fill the synchroniser before enabling.
    task automatic start_en();
        run(3);
        en = 1'b1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        resetn = 1'b1;
        en     = 1'b0;
        clr    = 1'b0;
        clk2   = 1'b0;
        phase  = 0;
        kind   = 0;
        b1     = 8'h00;
        b2     = 8'h00;

        vecs[0] = '{0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{1, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{2, 8'h00, 8'h00, 8'hFF, 8'hFF};
        vecs[3] = '{3, 8'hA5, 8'h5A, 8'hA5, 8'h5A};
        vecs[4] = '{3, 8'h01, 8'h80, 8'h01, 8'h80};
        vecs[5] = '{3, 8'hC3, 8'h3C, 8'hC3, 8'h3C};

        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            kind = vecs[i].kind;
            b1   = vecs[i].b1;
            b2   = vecs[i].b2;
            do_reset("vec_reset");
            start_en();
            run(63);
            check("vec_rdy_early", {7'd0, rdy}, 8'h00);
            run(1);
            check("vec_rdy_first", {7'd0, rdy}, 8'h01);
            check("vec_out_first", out, vecs[i].exp1);
            run(64);
            check("vec_rdy_second", {7'd0, rdy}, 8'h01);
            check("vec_out_second", out, vecs[i].exp2);
            $display("vector %0d kind=%0d out=%h rdy=%0b", i, kind, out, rdy);
        end

        // clr on the cycle rdy rises
        kind = 2;
        do_reset("clr_reset");
        start_en();
        run(64);
        check("clr_pre_rdy", {7'd0, rdy}, 8'h01);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_rdy", {7'd0, rdy}, 8'h00);
        check("clr_out_hold", out, 8'hFF);
        run(63);
        check("clr_rdy_early", {7'd0, rdy}, 8'h00);
        run(1);
        check("clr_rdy_again", {7'd0, rdy}, 8'h01);
        check("clr_out_again", out, 8'hFF);
        $display("clr sequence out=%h rdy=%0b", out, rdy);

        // clr coincident with byte completion
        kind = 4;
        b1   = 8'hA5;
        do_reset("coin_reset");
        start_en();
        run(64);
        check("coin_first_out", out, 8'hA5);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("coin_clr_rdy", {7'd0, rdy}, 8'h00);
        run(63);
        check("coin_rdy_early", {7'd0, rdy}, 8'h00);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("coin_rdy", {7'd0, rdy}, 8'h00);
        check("coin_out_hold", out, 8'hA5);
        run(63);
        check("coin_next_early", {7'd0, rdy}, 8'h00);
        run(1);
        check("coin_next_rdy", {7'd0, rdy}, 8'h01);
        check("coin_next_out", out, 8'h00);
        $display("coincident clr sequence out=%h rdy=%0b", out, rdy);

        // en dropped mid-byte
        kind = 2;
        do_reset("en_reset");
        start_en();
        run(64);
        clr = 1'b1;
        step();
        clr = 1'b0;
        run(30);
        en = 1'b0;
        run(10);
        check("en_off_rdy", {7'd0, rdy}, 8'h00);
        check("en_off_out", out, 8'hFF);
        en = 1'b1;
        run(63);
        check("en_back_early", {7'd0, rdy}, 8'h00);
        run(1);
        check("en_back_rdy", {7'd0, rdy}, 8'h01);
        check("en_back_out", out, 8'hFF);
        $display("en drop sequence out=%h rdy=%0b", out, rdy);

        // reset asserted mid-byte
        kind = 2;
        do_reset("mid_pre_reset");
        start_en();
        run(64);
        check("mid_pre_out", out, 8'hFF);
        run(20);
        do_reset("mid_async");
        start_en();
        run(63);
        check("mid_rdy_early", {7'd0, rdy}, 8'h00);
        run(1);
        check("mid_rdy", {7'd0, rdy}, 8'h01);
        check("mid_out", out, 8'hFF);
        $display("mid-byte reset sequence out=%h rdy=%0b", out, rdy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
